// File: rtl/popcount_pkg.sv
// Shared types and helpers for the sequential population counter.
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned f_ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/popcount_seq_if.sv
// Word-in / count-out handshake bundle for popcount_seq.
interface popcount_seq_if #(
  parameter int unsigned WIDTH = 16
) ();
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_zeros;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             busy;

  modport master (
    output in_valid, in_data, in_zeros, out_ready,
    input  in_ready, out_valid, out_count, busy
  );

  modport slave (
    input  in_valid, in_data, in_zeros, out_ready,
    output in_ready, out_valid, out_count, busy
  );
endinterface

// File: rtl/popcount_lane.sv
// Combinational bit counter for one chunk of N bits.
module popcount_lane #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]               bits,
  output logic [$clog2(N+1)-1:0]     count
);
  localparam int unsigned OW = $clog2(N + 1);

  // Written as a linear sum; synthesis rebalances it into an adder tree.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < N; i++) begin
      count = count + OW'(bits[i]);
    end
  end
endmodule

// File: rtl/popcount_seq.sv
// Multi-cycle population counter: LANES bits per cycle, valid/ready on both sides.
module popcount_seq
  import popcount_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 4
) (
  input logic          clk,
  input logic          reset,
  popcount_seq_if.slave bus
);
  localparam int unsigned CW        = $clog2(WIDTH + 1);
  localparam int unsigned CHUNKS    = f_ceil_div(WIDTH, LANES);
  localparam int unsigned IW        = $clog2(CHUNKS + 1);
  localparam int unsigned PW        = $clog2(LANES + 1);
  localparam int unsigned REM       = WIDTH % LANES;
  localparam int unsigned LAST_BITS = (REM == 0) ? LANES : REM;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    cnt_q;
  logic             ov_q;

  logic [LANES-1:0] last_mask;
  logic [LANES-1:0] lane_bits;
  logic [PW-1:0]    psum;
  logic             last_chunk;
  logic             load;
  logic             clear_out;
  logic             in_ready_c;

  assign last_chunk = (idx == IW'(CHUNKS - 1));

  // Final chunk of a non-multiple width only sees its low WIDTH%LANES bits.
  always_comb begin
    last_mask = '1;
    for (int unsigned i = 0; i < LANES; i++) begin
      last_mask[i] = (i < LAST_BITS);
    end
  end

  assign lane_bits = shreg[LANES-1:0] & (last_chunk ? last_mask : '1);

  popcount_lane #(.N(LANES)) u_lane (
    .bits  (lane_bits),
    .count (psum)
  );

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    load       = 1'b0;
    clear_out  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        in_ready_c = bus.out_ready;
        if (bus.out_ready) begin
          clear_out = 1'b1;
          if (bus.in_valid) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg   <= '0;
      idx     <= '0;
      acc     <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        shreg <= bus.in_zeros ? ~bus.in_data : bus.in_data;
        acc   <= '0;
        idx   <= '0;
      end else if (state_q == RUN) begin
        shreg <= shreg >> LANES;
        idx   <= idx + IW'(1);
        if (last_chunk) begin
          cnt_q <= acc + CW'(psum);
          ov_q  <= 1'b1;
        end else begin
          acc <= acc + CW'(psum);
        end
      end
      if (clear_out) ov_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = ov_q;
  assign bus.out_count = cnt_q;
  assign bus.busy      = (state_q == RUN);

endmodule

// File: tb/tb_popcount_seq.sv
// Directed bench for popcount_seq across four width/lane configurations.
module tb_popcount_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_zeros;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  popcount_seq_if #(.WIDTH(16)) bus_a ();
  popcount_seq_if #(.WIDTH(10)) bus_b ();
  popcount_seq_if #(.WIDTH(16)) bus_c ();
  popcount_seq_if #(.WIDTH(16)) bus_d ();

  popcount_seq #(.WIDTH(16), .LANES(4))  dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  popcount_seq #(.WIDTH(10), .LANES(4))  dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));
  popcount_seq #(.WIDTH(16), .LANES(1))  dut_c (.clk(clk), .reset(reset), .bus(bus_c.slave));
  popcount_seq #(.WIDTH(16), .LANES(16)) dut_d (.clk(clk), .reset(reset), .bus(bus_d.slave));

  assign bus_a.in_valid = in_valid && (sel == 2'd0);
  assign bus_b.in_valid = in_valid && (sel == 2'd1);
  assign bus_c.in_valid = in_valid && (sel == 2'd2);
  assign bus_d.in_valid = in_valid && (sel == 2'd3);
  assign bus_a.in_data  = in_data;
  assign bus_b.in_data  = in_data[9:0];
  assign bus_c.in_data  = in_data;
  assign bus_d.in_data  = in_data;
  assign bus_a.in_zeros = in_zeros;
  assign bus_b.in_zeros = in_zeros;
  assign bus_c.in_zeros = in_zeros;
  assign bus_d.in_zeros = in_zeros;
  assign bus_a.out_ready = out_ready;
  assign bus_b.out_ready = out_ready;
  assign bus_c.out_ready = out_ready;
  assign bus_d.out_ready = out_ready;

  logic [3:0] ov_v, ir_v, busy_v;
  logic [4:0] cnt_v [4];
  assign ov_v   = {bus_d.out_valid, bus_c.out_valid, bus_b.out_valid, bus_a.out_valid};
  assign ir_v   = {bus_d.in_ready,  bus_c.in_ready,  bus_b.in_ready,  bus_a.in_ready};
  assign busy_v = {bus_d.busy,      bus_c.busy,      bus_b.busy,      bus_a.busy};
  assign cnt_v[0] = bus_a.out_count;
  assign cnt_v[1] = {1'b0, bus_b.out_count};
  assign cnt_v[2] = bus_c.out_count;
  assign cnt_v[3] = bus_d.out_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int d, input logic [15:0] data, input logic z, input string tag);
    sel      = 2'(d);
    in_data  = data;
    in_zeros = z;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(ir_v[d]), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int d, input int exp_cnt, input int exp_lat, input string tag);
    int lat = 0;
    while (ov_v[d] !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_count"}, 32'(cnt_v[d]), 32'(exp_cnt));
  endtask

  task automatic do_word(input int d, input logic [15:0] data, input logic z,
                         input int exp_cnt, input int exp_lat, input string tag);
    out_ready = 1'b1;
    accept(d, data, z, tag);
    wait_result(d, exp_cnt, exp_lat, tag);
    tick();
  endtask

  initial begin
    logic        seen;
    logic        stable;
    logic [15:0] w;
    logic        z;

    reset = 1'b1; sel = '0; in_valid = 1'b0; in_data = '0; in_zeros = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset_out_valid_%0d", d), 32'(ov_v[d]), 32'd0);
      chk($sformatf("reset_out_count_%0d", d), 32'(cnt_v[d]), 32'd0);
      chk($sformatf("reset_busy_%0d", d), 32'(busy_v[d]), 32'd0);
    end
    reset = 1'b0;
    tick();

    // Reset two cycles into a run: word is dropped, block returns to IDLE
    accept(0, 16'hFFFF, 1'b0, "midrun");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrun_busy", 32'(busy_v[0]), 32'd0);
    chk("midrun_out_valid", 32'(ov_v[0]), 32'd0);
    chk("midrun_out_count", 32'(cnt_v[0]), 32'd0);
    chk("midrun_in_ready", 32'(ir_v[0]), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ov_v[0] !== 1'b0) seen = 1'b1;
    end
    chk("midrun_no_stale", 32'(seen), 32'd0);

    // Default configuration latency and busy flag
    out_ready = 1'b1;
    accept(0, 16'hA5F0, 1'b0, "a5f0");
    chk("a5f0_busy", 32'(busy_v[0]), 32'd1);
    chk("a5f0_in_ready_run", 32'(ir_v[0]), 32'd0);
    wait_result(0, 8, 4, "a5f0");
    tick();

    do_word(0, 16'h0001, 1'b1, 15, 4, "zeros_0001");
    do_word(0, 16'h0000, 1'b1, 16, 4, "zeros_0000");
    do_word(0, 16'hFFFF, 1'b1, 0,  4, "zeros_ffff");
    do_word(0, 16'h1234, 1'b0, 5,  4, "ones_1234");

    // WIDTH=10, LANES=4: third chunk only has two real bits
    do_word(1, 16'h03FF, 1'b1, 0,  3, "w10_zeros_3ff");
    do_word(1, 16'h03FF, 1'b0, 10, 3, "w10_ones_3ff");
    do_word(1, 16'h02A5, 1'b1, 5,  3, "w10_zeros_2a5");
    do_word(1, 16'h0300, 1'b0, 2,  3, "w10_ones_300");

    // Back-pressure, then same-edge release and accept
    out_ready = 1'b0;
    accept(0, 16'h1234, 1'b0, "bp");
    wait_result(0, 5, 4, "bp");
    in_data  = 16'h8001;
    in_zeros = 1'b0;
    in_valid = 1'b1;
    stable   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cnt_v[0] !== 5'd5 || ov_v[0] !== 1'b1 || ir_v[0] !== 1'b0) stable = 1'b0;
    end
    chk("bp_hold_stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(ir_v[0]), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b_out_valid_cleared", 32'(ov_v[0]), 32'd0);
    chk("b2b_busy", 32'(busy_v[0]), 32'd1);
    wait_result(0, 2, 4, "b2b");
    tick();

    // LANES=1 and LANES=16 extremes
    do_word(2, 16'hA5F0, 1'b0, 8,  16, "l1_a5f0");
    do_word(3, 16'hA5F0, 1'b0, 8,  1,  "l16_a5f0");
    do_word(3, 16'h0001, 1'b1, 15, 1,  "l16_zeros_0001");
    do_word(2, 16'h8000, 1'b0, 1,  16, "l1_8000");
    for (int i = 0; i < 6; i++) begin
      w = 16'($urandom);
      z = 1'($urandom_range(1, 0));
      do_word(2, w, z, z ? 16 - $countones(w) : $countones(w), 16, $sformatf("l1_rand%0d", i));
      do_word(3, w, z, z ? 16 - $countones(w) : $countones(w), 1,  $sformatf("l16_rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
